// File: rtl/tf_call_responder.sv
// tf_call_responder: callee side of the call interface; queues requests, checks arity and
// existence, evaluates the function and returns result plus status over a valid/ready channel.
module tf_call_responder #(
    parameter int DEPTH = 4,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [1:0]    req_func,
    input  logic [1:0]    req_argc,
    input  logic [DW-1:0] req_a,
    input  logic [DW-1:0] req_b,
    input  logic          req_void,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic [1:0]    rsp_status,
    output logic          busy,
    output logic [7:0]    err_count
);
    localparam int AW = $clog2(DEPTH);
    typedef struct packed {
        logic [1:0]    func;
        logic [1:0]    argc;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          vd;
    } call_t;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    call_t         mem_q [DEPTH];
    call_t         call_q;
    state_t        state_q;
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic          full, empty, push, pop;
    logic [1:0]    arity, status_d;
    logic [DW-1:0] dbl, result_d;
    logic          rsp_valid_q;
    logic [DW-1:0] rsp_data_q;
    logic [1:0]    rsp_status_q;
    logic [7:0]    err_count_q;
    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = wr_ptr_q == rd_ptr_q;
    assign push  = req_valid && !full;
    assign pop   = state_q == IDLE && !empty;
    assign req_ready  = !full;
    assign busy       = !empty || state_q != IDLE;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_status = rsp_status_q;
    assign err_count  = err_count_q;
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q[AW-1:0]] <= '{req_func, req_argc, req_a, req_b, req_void};
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end
    // DOUBLE wraps at 4 bits: only a[2:0] survives the shift.
    always_comb begin
        arity    = call_q.func == 2'd0 ? 2'd2 : call_q.func == 2'd1 ? 2'd1 : 2'd0;
        status_d = call_q.func == 2'd3 ? 2'd2 : call_q.argc != arity ? 2'd1 : 2'd0;
        dbl      = {{(DW-4){1'b0}}, call_q.a[2:0], 1'b0};
        result_d = status_d != 2'd0 ? '0 :
                   call_q.func == 2'd0 ? call_q.a + call_q.b :
                   call_q.func == 2'd1 ? dbl : DW'(1);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            call_q       <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_status_q <= 2'd0;
            err_count_q  <= 8'd0;
        end else begin
            case (state_q)
                IDLE: if (!empty) begin
                    call_q  <= mem_q[rd_ptr_q[AW-1:0]];
                    state_q <= EXEC;
                end
                EXEC: begin
                    rsp_data_q   <= result_d;
                    rsp_status_q <= status_d;
                    if (status_d != 2'd0 && err_count_q != 8'hFF)
                        err_count_q <= err_count_q + 8'd1;
                    if (call_q.vd && status_d == 2'd0) begin
                        state_q <= IDLE;
                    end else begin
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                RESP: if (rsp_ready) begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
